// File: rtl/pacote_banco.sv
// Shared definitions for the register-bank arbiter: FSM encoding, size defaults
// and requester identifiers.
package pacote_banco;

    // Default geometry of the 16x8 register bank
    localparam int unsigned NREG_PADRAO = 16;
    localparam int unsigned ADDR_PADRAO = 4;
    localparam int unsigned LARG_PADRAO = 8;

    // Sequencer states; INICIALIZA is only reachable when the sweep is compiled in
    typedef enum logic [1:0] {
        INICIALIZA = 2'd0,
        OCIOSO     = 2'd1,
        LEITURA    = 2'd2,
        ESCRITA    = 2'd3
    } estado_t;

    // Requester identifiers, also the encoding of the round-robin pointer
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-input round-robin arbiter. Purely combinational: on a tie the requester
// that was not served last (ultimo) wins.
module arbitro_rr2
    import pacote_banco::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic ultimo,
    output logic concede,
    output logic vencedor
);

    // Grant selection
    always_comb begin
        concede  = req_a | req_b;
        vencedor = REQ_A;
        if (req_a && req_b) begin
            vencedor = (ultimo == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            vencedor = REQ_B;
        end
    end

endmodule

// File: rtl/arbitro_banco_registradores.sv
// Sequencer/arbiter sharing the register bank's two read ports and one write port
// between requester A (datapath) and requester B (loader/debug).
// Optional post-reset zeroing sweep: define ARBITRO_LIMPEZA_INICIAL_EN.
// All bank-side signals are registered, so banco_write only moves on rising edges
// (or on the asynchronous reset).
module arbitro_banco_registradores
    import pacote_banco::*;
#(
    parameter int unsigned NREG = NREG_PADRAO,
    parameter int unsigned ADDR = ADDR_PADRAO,
    parameter int unsigned LARG = LARG_PADRAO
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req_a,
    input  logic            req_b,
    input  logic            esc_a,
    input  logic            esc_b,
    input  logic [ADDR-1:0] end1_a,
    input  logic [ADDR-1:0] end2_a,
    input  logic [ADDR-1:0] end1_b,
    input  logic [ADDR-1:0] end2_b,
    input  logic [ADDR-1:0] ende_a,
    input  logic [ADDR-1:0] ende_b,
    input  logic [LARG-1:0] dado_a,
    input  logic [LARG-1:0] dado_b,
    output logic            ack_a,
    output logic            ack_b,
    output logic [LARG-1:0] rd1,
    output logic [LARG-1:0] rd2,
    output logic            ocupado,
    output logic [ADDR-1:0] banco_entrada1,
    output logic [ADDR-1:0] banco_entrada2,
    output logic [ADDR-1:0] banco_escrita,
    output logic [LARG-1:0] banco_dado,
    output logic            banco_write,
    input  logic [LARG-1:0] banco_saida1,
    input  logic [LARG-1:0] banco_saida2
);

    estado_t         estado_q, estado_d;
    logic            ultimo_q, ultimo_d;
    logic            sel_q, sel_d;
    logic            ack_a_q, ack_a_d;
    logic            ack_b_q, ack_b_d;
    logic [LARG-1:0] rd1_q, rd1_d;
    logic [LARG-1:0] rd2_q, rd2_d;
    logic [ADDR-1:0] ent1_q, ent1_d;
    logic [ADDR-1:0] ent2_q, ent2_d;
    logic [ADDR-1:0] escr_q, escr_d;
    logic [LARG-1:0] dado_q, dado_d;
    logic            write_q, write_d;
`ifdef ARBITRO_LIMPEZA_INICIAL_EN
    logic            ocupado_q, ocupado_d;
    logic [ADDR-1:0] cont_q, cont_d;
`endif

    logic            req_a_m, req_b_m;
    logic            concede, vencedor;
    logic            g_esc;
    logic [ADDR-1:0] g_end1, g_end2, g_ende;
    logic [LARG-1:0] g_dado;

    // A requester is masked during its own ack cycle so a late release is not re-granted
    always_comb begin
        req_a_m = req_a & ~ack_a_q;
        req_b_m = req_b & ~ack_b_q;
    end

    arbitro_rr2 u_rr (
        .req_a   (req_a_m),
        .req_b   (req_b_m),
        .ultimo  (ultimo_q),
        .concede (concede),
        .vencedor(vencedor)
    );

    // Fields of the winning requester
    always_comb begin
        if (vencedor == REQ_B) begin
            g_esc  = esc_b;
            g_end1 = end1_b;
            g_end2 = end2_b;
            g_ende = ende_b;
            g_dado = dado_b;
        end else begin
            g_esc  = esc_a;
            g_end1 = end1_a;
            g_end2 = end2_a;
            g_ende = ende_a;
            g_dado = dado_a;
        end
    end

    // Next state and next values of all registered outputs
    always_comb begin
        estado_d = estado_q;
        ultimo_d = ultimo_q;
        sel_d    = sel_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        ent1_d   = ent1_q;
        ent2_d   = ent2_q;
        escr_d   = escr_q;
        dado_d   = dado_q;
        write_d  = 1'b0;
`ifdef ARBITRO_LIMPEZA_INICIAL_EN
        ocupado_d = 1'b0;
        cont_d    = cont_q;
`endif
        unique case (estado_q)
`ifdef ARBITRO_LIMPEZA_INICIAL_EN
            INICIALIZA: begin
                // Drive one zero-write per cycle; the bank commits it on the next edge
                write_d   = 1'b1;
                escr_d    = cont_q;
                dado_d    = '0;
                ocupado_d = 1'b1;
                cont_d    = cont_q + 1'b1;
                if (cont_q == ADDR'(NREG - 1)) begin
                    cont_d   = '0;
                    estado_d = OCIOSO;
                end
            end
`endif
            OCIOSO: begin
                if (concede) begin
                    sel_d = vencedor;
                    if (g_esc) begin
                        estado_d = ESCRITA;
                        write_d  = 1'b1;
                        escr_d   = g_ende;
                        dado_d   = g_dado;
                    end else begin
                        estado_d = LEITURA;
                        ent1_d   = g_end1;
                        ent2_d   = g_end2;
                    end
                end
            end
            LEITURA: begin
                // Bank outputs settled on the falling edge inside this cycle
                rd1_d    = banco_saida1;
                rd2_d    = banco_saida2;
                ack_a_d  = (sel_q == REQ_A);
                ack_b_d  = (sel_q == REQ_B);
                ultimo_d = sel_q;
                estado_d = OCIOSO;
            end
            ESCRITA: begin
                ack_a_d  = (sel_q == REQ_A);
                ack_b_d  = (sel_q == REQ_B);
                ultimo_d = sel_q;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by clr
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
`ifdef ARBITRO_LIMPEZA_INICIAL_EN
            estado_q  <= INICIALIZA;
            ocupado_q <= 1'b0;
            cont_q    <= '0;
`else
            estado_q  <= OCIOSO;
`endif
            ultimo_q  <= REQ_B;
            sel_q     <= REQ_A;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            ent1_q    <= '0;
            ent2_q    <= '0;
            escr_q    <= '0;
            dado_q    <= '0;
            write_q   <= 1'b0;
        end else begin
`ifdef ARBITRO_LIMPEZA_INICIAL_EN
            ocupado_q <= ocupado_d;
            cont_q    <= cont_d;
`endif
            estado_q  <= estado_d;
            ultimo_q  <= ultimo_d;
            sel_q     <= sel_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            ent1_q    <= ent1_d;
            ent2_q    <= ent2_d;
            escr_q    <= escr_d;
            dado_q    <= dado_d;
            write_q   <= write_d;
        end
    end

    assign ack_a          = ack_a_q;
    assign ack_b          = ack_b_q;
    assign rd1            = rd1_q;
    assign rd2            = rd2_q;
    assign banco_entrada1 = ent1_q;
    assign banco_entrada2 = ent2_q;
    assign banco_escrita  = escr_q;
    assign banco_dado     = dado_q;
    assign banco_write    = write_q;
`ifdef ARBITRO_LIMPEZA_INICIAL_EN
    assign ocupado        = ocupado_q;
`else
    assign ocupado        = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_banco_registradores.sv
// Self-checking bench for arbitro_banco_registradores with a behavioural 16x8 bank
// (writes on rising edge, outputs refresh on falling edge), preloaded with 0xFF.
module tb_arbitro_banco_registradores;

`ifdef ARBITRO_LIMPEZA_INICIAL_EN
    localparam int         SWEEP = 16;
    localparam logic [7:0] INI   = 8'h00;
`else
    localparam int         SWEEP = 0;
    localparam logic [7:0] INI   = 8'hFF;
`endif

    logic       clk, clr;
    logic       req_a, req_b, esc_a, esc_b;
    logic [3:0] end1_a, end2_a, end1_b, end2_b, ende_a, ende_b;
    logic [7:0] dado_a, dado_b;
    logic       ack_a, ack_b, ocupado, banco_write;
    logic [7:0] rd1, rd2, banco_dado, banco_saida1, banco_saida2;
    logic [3:0] banco_entrada1, banco_entrada2, banco_escrita;

    logic [7:0] mem [16] = '{default: 8'hFF};

    int n_vec = 0;
    int n_err = 0;

    arbitro_banco_registradores dut (
        .clk           (clk),
        .clr           (clr),
        .req_a         (req_a),
        .req_b         (req_b),
        .esc_a         (esc_a),
        .esc_b         (esc_b),
        .end1_a        (end1_a),
        .end2_a        (end2_a),
        .end1_b        (end1_b),
        .end2_b        (end2_b),
        .ende_a        (ende_a),
        .ende_b        (ende_b),
        .dado_a        (dado_a),
        .dado_b        (dado_b),
        .ack_a         (ack_a),
        .ack_b         (ack_b),
        .rd1           (rd1),
        .rd2           (rd2),
        .ocupado       (ocupado),
        .banco_entrada1(banco_entrada1),
        .banco_entrada2(banco_entrada2),
        .banco_escrita (banco_escrita),
        .banco_dado    (banco_dado),
        .banco_write   (banco_write),
        .banco_saida1  (banco_saida1),
        .banco_saida2  (banco_saida2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model
    always @(posedge clk) if (banco_write) mem[banco_escrita] <= banco_dado;
    always @(negedge clk) begin
        banco_saida1 <= mem[banco_entrada1];
        banco_saida2 <= mem[banco_entrada2];
    end

    typedef struct {
        logic       lado;   // 0 = A, 1 = B
        logic       esc;
        logic [3:0] e1, e2, ee;
        logic [7:0] dado;
        logic [7:0] x1, x2; // expected rd1/rd2 at ack
    } vet_t;

    vet_t tab [9];

    task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    task automatic dirige(input logic lado, input logic esc, input logic [3:0] e1,
                          input logic [3:0] e2, input logic [3:0] ee, input logic [7:0] d);
        if (lado) begin
            req_b = 1'b1; esc_b = esc; end1_b = e1; end2_b = e2; ende_b = ee; dado_b = d;
        end else begin
            req_a = 1'b1; esc_a = esc; end1_a = e1; end2_a = e2; ende_a = ee; dado_a = d;
        end
    endtask

    task automatic solta(input logic lado);
        if (lado) req_b = 1'b0;
        else req_a = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nome);
        chk(nome, {ocupado, banco_write, ack_a, ack_b, rd1, rd2, banco_entrada1,
                   banco_entrada2, banco_escrita, banco_dado}, 64'd0);
    endtask

    // Called at the falling edge where clr is released with A's read already pending
    task automatic apos_reset(input logic [7:0] x1, input logic [7:0] x2);
        for (int k = 1; k <= SWEEP + 2; k++) begin
            tick();
            if (k <= SWEEP) begin
                chk($sformatf("sweep%0d ocupado", k), ocupado, 1'b1);
                chk($sformatf("sweep%0d write", k), banco_write, 1'b1);
                chk($sformatf("sweep%0d addr", k), banco_escrita, 4'(k - 1));
                chk($sformatf("sweep%0d data", k), banco_dado, 8'h00);
            end
            if (k == SWEEP + 1) chk("ocupado after sweep", ocupado, 1'b0);
            chk($sformatf("post-reset ack_a k=%0d", k), ack_a, k == SWEEP + 2);
        end
        chk("post-reset rd1", rd1, x1);
        chk("post-reset rd2", rd2, x2);
    endtask

    task automatic run_vec(input vet_t v, input int i);
        dirige(v.lado, v.esc, v.e1, v.e2, v.ee, v.dado);
        tick();
        chk($sformatf("v%0d op write", i), banco_write, v.esc);
        if (v.esc) chk($sformatf("v%0d op wr addr", i), {banco_escrita, banco_dado},
                       {v.ee, v.dado});
        else chk($sformatf("v%0d op rd addr", i), {banco_entrada1, banco_entrada2},
                 {v.e1, v.e2});
        tick();
        chk($sformatf("v%0d acks", i), {ack_a, ack_b}, v.lado ? 2'b01 : 2'b10);
        chk($sformatf("v%0d rd1", i), rd1, v.x1);
        chk($sformatf("v%0d rd2", i), rd2, v.x2);
        solta(v.lado);
        tick();
    endtask

    initial begin
        clr = 1'b0;
        {req_a, req_b, esc_a, esc_b} = '0;
        {end1_a, end2_a, end1_b, end2_b, ende_a, ende_b} = '0;
        {dado_a, dado_b} = '0;

        tab[0] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd3,  8'h5A, INI,   INI};
        tab[1] = '{1'b0, 1'b0, 4'd3,  4'd0,  4'd0,  8'h00, 8'h5A, INI};
        tab[2] = '{1'b1, 1'b1, 4'd0,  4'd0,  4'd9,  8'hC3, 8'h5A, INI};
        tab[3] = '{1'b1, 1'b0, 4'd9,  4'd3,  4'd0,  8'h00, 8'hC3, 8'h5A};
        tab[4] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd0,  8'h01, 8'hC3, 8'h5A};
        tab[5] = '{1'b0, 1'b0, 4'd0,  4'd15, 4'd0,  8'h00, 8'h01, INI};
        tab[6] = '{1'b1, 1'b1, 4'd0,  4'd0,  4'd15, 8'h80, 8'h01, INI};
        tab[7] = '{1'b0, 1'b0, 4'd15, 4'd9,  4'd0,  8'h00, 8'h80, 8'hC3};
        tab[8] = '{1'b1, 1'b0, 4'd3,  4'd0,  4'd0,  8'h00, 8'h5A, 8'h01};

        // Reset state, then A reads r15/r0 straight from reset release
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset outputs");
        dirige(1'b0, 1'b0, 4'd15, 4'd0, 4'd0, 8'h00);
        clr = 1'b1;
        apos_reset(INI, INI);
        solta(1'b0);
        tick();

        // Single-requester table
        for (int i = 0; i < 9; i++) run_vec(tab[i], i);

        // Simultaneous requests: A writes r7, B reads r7
        dirige(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 8'h11);
        dirige(1'b1, 1'b0, 4'd7, 4'd3, 4'd0, 8'h00);
        tick();
        chk("tie first grant is A write", {banco_write, banco_escrita}, {1'b1, 4'd7});
        tick();
        chk("tie ack A", {ack_a, ack_b}, 2'b10);
        solta(1'b0);
        tick();
        chk("tie B op read", {banco_write, banco_entrada1}, {1'b0, 4'd7});
        tick();
        chk("tie ack B", {ack_a, ack_b}, 2'b01);
        chk("tie B rd1", rd1, 8'h11);
        chk("tie B rd2", rd2, 8'h5A);
        solta(1'b1);
        tick();

        // Both held: grants alternate A, B, A, B
        dirige(1'b0, 1'b0, 4'd0, 4'd9, 4'd0, 8'h00);
        dirige(1'b1, 1'b0, 4'd3, 4'd15, 4'd0, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("alt acks k=%0d", k), {ack_a, ack_b},
                {(k == 2 || k == 6), (k == 4 || k == 8)});
            if (ack_a) chk($sformatf("alt A rd k=%0d", k), {rd1, rd2}, {8'h01, 8'hC3});
            if (ack_b) chk($sformatf("alt B rd k=%0d", k), {rd1, rd2}, {8'h5A, 8'h80});
        end
        solta(1'b0);
        solta(1'b1);
        tick();
        chk("alt idle", {ack_a, ack_b}, 2'b00);

        // A keeps req_a one cycle past its ack: no duplicate grant
        dirige(1'b0, 1'b0, 4'd9, 4'd0, 4'd0, 8'h00);
        tick();
        tick();
        chk("stale ack", ack_a, 1'b1);
        chk("stale rd", {rd1, rd2}, {8'hC3, 8'h01});
        tick();
        solta(1'b0);
        for (int k = 3; k <= 5; k++) begin
            chk($sformatf("stale no regrant k=%0d", k), {ack_a, banco_entrada1 == 4'd9 &&
                                                          banco_write}, 2'b00);
            tick();
        end

        // clr pulsed during ESCRITA of r1=0x77: dropped, no ack, outputs cleared
        dirige(1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 8'h77);
        tick();
        chk("esc before reset", banco_write, 1'b1);
        #2;
        clr = 1'b0;
        #1;
        chk_zero("mid-op reset outputs");
        tick();
        chk("no ack in reset", {ack_a, ack_b, banco_write}, 3'b000);
        @(negedge clk);
        dirige(1'b0, 1'b0, 4'd1, 4'd3, 4'd0, 8'h00);
        clr = 1'b1;
        apos_reset(INI, SWEEP > 0 ? 8'h00 : 8'h5A);
        solta(1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arbitro_banco_registradores.md
# arbitro_banco_registradores

- Sequencer and arbiter in front of the 16×8 register bank (`bancoRegistradores`).
- Shares the bank's two read ports and one write port between two requesters:
  - A: datapath writeback/operand fetch.
  - B: loader/debug port.
- Converts request/acknowledge transactions into the bank's `write`-qualified edge protocol.
- Optionally zeroes all 16 registers after reset by a write sweep.

## Interface
- `NREG`, 16, number of bank registers (power of two).
- `ADDR`, 4, register address width, log2(`NREG`).
- `LARG`, 8, data width.
- `clk`  in  1  single clock; bank is clocked by the same `clk`.
- `clr`  in  1  reset, asynchronous, active-low (asserted when 0).
- `req_a`, `req_b`  in  1  transaction request; held with fields stable until the matching ack.
- `esc_a`, `esc_b`  in  1  1 = write, 0 = read.
- `end1_a`, `end2_a`, `end1_b`, `end2_b`  in  `ADDR`  read addresses.
- `ende_a`, `ende_b`  in  `ADDR`  write address.
- `dado_a`, `dado_b`  in  `LARG`  write data.
- `ack_a`, `ack_b`  out  1  one-cycle completion pulse, registered.
- `rd1`, `rd2`  out  `LARG`  read data; valid in the cycle the ack of a read is high, then held.
- `ocupado`  out  1  high while the init sweep runs.
- `banco_entrada1`, `banco_entrada2`  out  `ADDR`  to bank read addresses.
- `banco_escrita`  out  `ADDR`  to bank write address.
- `banco_dado`  out  `LARG`  to bank write data.
- `banco_write`  out  1  to bank `write`.
- `banco_saida1`, `banco_saida2`  in  `LARG`  from bank outputs.
- The bank's own `clr` is tied inactive. Clearing is done only through this block.

## Operation
- States: `INICIALIZA`, `OCIOSO`, `LEITURA`, `ESCRITA`.
- **Reset** (`clr`=0, asynchronous):
  - All outputs are 0.
  - Round-robin pointer `ultimo` = B, so A wins the first tie.
  - Sweep counter = 0.
  - State = `INICIALIZA` if the sweep is compiled in, otherwise `OCIOSO`.
- **`INICIALIZA`**:
  - `banco_write`=1, `banco_escrita`=counter, `banco_dado`=0, `ocupado`=1.
  - Counter increments each cycle.
  - After writing address `NREG`-1 the counter wraps to 0, state goes to `OCIOSO`, and `ocupado` drops.
  - Requests are ignored during the sweep and are not lost: they are served afterwards.
- **`OCIOSO`**: `banco_write`=0. Arbitration at each rising edge:
  - Only one valid request: grant it.
  - Both valid: grant the one that is not `ultimo`.
  - Next state is `ESCRITA` or `LEITURA` per the granted `esc_x`.
  - Granted fields are latched into internal registers and driven to the bank from the next cycle on.
- **`LEITURA`** (1 cycle):
  - Drives `banco_entrada1`/`banco_entrada2`, with `banco_write`=0.
  - The bank updates its outputs on the falling edge inside this cycle.
  - At the closing rising edge: `rd1`/`rd2` ← `banco_saida1`/`banco_saida2`, ack of the granted requester = 1, `ultimo` ← granted, state → `OCIOSO`.
- **`ESCRITA`** (1 cycle):
  - Drives `banco_escrita`/`banco_dado`, with `banco_write`=1. The bank writes on the rising edge that closes this cycle.
  - At that edge: ack = 1, `ultimo` ← granted, state → `OCIOSO`. `rd1`/`rd2` are unchanged.
- **Ack-cycle masking**: in the `OCIOSO` cycle where `ack_x`=1, requester x's `req` is masked from arbitration. This prevents a duplicate grant if x releases late.
- **Read of the register just written**: a read issued after a write's ack returns the new value. Ordering is strictly serial, so no forwarding is needed.

## Timing
- `req` high in `OCIOSO` cycle t → operation cycle t+1 → ack and data in cycle t+2.
- Minimum spacing between grants is 2 cycles.
- Both requesting continuously: grants alternate A, B, A, … Each requester gets one transaction per 4 cycles.
- `banco_write` is never high outside `INICIALIZA`/`ESCRITA`. It changes only on rising edges.
- Reset mid-operation: the transaction is dropped with no ack. If compiled in, the sweep restarts from address 0.
- `clr` released mid-cycle: the first state transition happens at the next rising edge.

## Configuration
- Macro: `ARBITRO_LIMPEZA_INICIAL_EN`.
- **Defined**: after reset the `INICIALIZA` sweep takes `NREG` cycles; `ocupado` is high for exactly `NREG` cycles.
- **Undefined**:
  - No `INICIALIZA` state and no sweep counter.
  - Reset enters `OCIOSO` directly.
  - `ocupado` is tied to 0.
  - Bank contents after reset are whatever the bank holds.

## Structure
- Package `pacote_banco` holds:
  - state encoding constants (`INICIALIZA`=0, `OCIOSO`=1, `LEITURA`=2, `ESCRITA`=3);
  - `NREG`, `ADDR`, `LARG` defaults;
  - requester IDs `REQ_A`=0, `REQ_B`=1.
- One sub-module, `arbitro_rr2`: two-input round-robin.
  - Inputs: masked requests and `ultimo`.
  - Output: the grant, combinational.
- The FSM, field latches, sweep counter and ack/data registers stay in the top module.

## Test plan
- Reset with macro defined → `ocupado`=1 for 16 cycles and `banco_write`=1 at addresses 0..15 with data 0; then a read of r15 from A returns `rd1`=0x00.
- A writes 0x5A to r3, then reads `end1`=3, `end2`=0 → `ack_a` 2 cycles after each request; `rd1`=0x5A, `rd2`=0x00.
- A and B request in the same cycle:
  - A writes r7=0x11; B reads r7.
  - A is granted first; B's ack comes 2 cycles after A's, with `rd1`=0x11.
  - With both held high, grants continue alternating A, B, A, B.
- A requests at reset release with the macro defined → no ack during the sweep; `ack_a` arrives in cycle `NREG`+2.
- `clr` pulsed low during `ESCRITA` → no ack, all outputs 0; the sweep restarts at address 0. With the macro undefined, the state is `OCIOSO` immediately after release.
- Requester holds `req_a` one cycle past `ack_a` → no second grant to A from that stale request.
